// File: rtl/fpu_issue_pkg.sv
// Shared types for the FPU issue/reorder block: the packed FPU control word,
// the reorder-buffer entry layout and a saturating counter helper.
package fpu_issue_pkg;

  localparam int unsigned CTRL_W   = 17;
  localparam int unsigned STATUS_W = 5;
  localparam int unsigned ROB_FLEN = 64;

  // Field widths follow the FPU wrapper's enum ports, MSB first.
  typedef struct packed {
    logic [2:0] rnd_mode;
    logic [3:0] op;
    logic       op_mod;
    logic [2:0] src_fmt;
    logic [2:0] dst_fmt;
    logic [1:0] int_fmt;
    logic       vectorial;
  } ctrl_t;

  typedef struct packed {
    logic [ROB_FLEN-1:0] result;
    logic [STATUS_W-1:0] status;
  } rob_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fpu_issue_rob_mem.sv
// Reorder-buffer storage: one entry plus a done bit per tag. Results are
// written by tag, read at the head slot; flush clears every done bit.
module fpu_issue_rob_mem
  import fpu_issue_pkg::*;
#(
  parameter int unsigned IDX_W = 2,
  parameter type         entry_t = rob_entry_t
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  entry_t           wr_data_i,
  input  logic             alloc_en_i,
  input  logic [IDX_W-1:0] alloc_idx_i,
  input  logic             pop_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output entry_t           rd_data_o,
  output logic             rd_done_o
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  entry_t             entries_q [DEPTH];
  logic   [DEPTH-1:0] done_q;
  logic   [DEPTH-1:0] done_d;

  // Results arriving during a flush belong to killed work and are dropped.
  logic wr_take;
  assign wr_take = wr_en_i && !flush_i;

  // Done-bit update: allocation and pop clear, a returning result sets.
  always_comb begin
    done_d = done_q;
    if (alloc_en_i) done_d[alloc_idx_i] = 1'b0;
    if (pop_en_i)   done_d[rd_idx_i]    = 1'b0;
    if (wr_take)    done_d[wr_idx_i]    = 1'b1;
    if (flush_i)    done_d              = '0;
  end

  // Done-bit state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

  // Entry storage, written by returning tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entries_q <= '{default: '0};
    end else if (wr_take) begin
      entries_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = entries_q[rd_idx_i];
  assign rd_done_o = done_q[rd_idx_i];

endmodule

// File: rtl/fpu_issue_rob.sv
// Issue side of the FPU handshake with an in-order reorder buffer. Requests
// get a tag from the tail pointer, are held in an issue register towards the
// FPU, and results (possibly out of order) are retired from the head.
// Optional build macro FPU_ISSUE_STATS_EN adds saturating issue/stall counters.
module fpu_issue_rob
  import fpu_issue_pkg::*;
#(
  parameter int unsigned FLEN      = 64,
  parameter int unsigned TAG_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [3*FLEN-1:0]     req_operands_i,
  input  ctrl_t                 req_ctrl_i,
  input  logic                  flush_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [FLEN-1:0]       rsp_result_o,
  output logic [STATUS_W-1:0]   rsp_status_o,
  output logic                  busy_o,
  output logic                  fpu_in_valid_o,
  input  logic                  fpu_in_ready_i,
  output logic [3*FLEN-1:0]     fpu_operands_o,
  output ctrl_t                 fpu_ctrl_o,
  output logic [TAG_WIDTH-1:0]  fpu_tag_o,
  output logic                  fpu_flush_o,
  input  logic                  fpu_out_valid_i,
  output logic                  fpu_out_ready_o,
  input  logic [FLEN-1:0]       fpu_result_i,
  input  logic [STATUS_W-1:0]   fpu_status_i,
  input  logic [TAG_WIDTH-1:0]  fpu_tag_i,
  input  logic                  fpu_busy_i
`ifdef FPU_ISSUE_STATS_EN
  ,
  output logic [31:0]           stat_issued_o,
  output logic [31:0]           stat_stall_o
`endif
);

  localparam int unsigned DEPTH = 2 ** TAG_WIDTH;
  localparam int unsigned CNT_W = TAG_WIDTH + 1;

  typedef struct packed {
    logic [FLEN-1:0]     result;
    logic [STATUS_W-1:0] status;
  } entry_t;

  logic [TAG_WIDTH-1:0] head_q, tail_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 in_valid_q;
  logic [3*FLEN-1:0]    ops_q;
  ctrl_t                ctrl_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 active_q;

  logic   accept, drain, head_done;
  entry_t wr_entry, rd_entry;

  // Held low while in reset so every output reads zero until release.
  assign req_ready_o = active_q && !flush_i && (count_q != CNT_W'(DEPTH)) &&
                       (!in_valid_q || fpu_in_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  assign rsp_valid_o  = head_done && (count_q != '0) && !flush_i;
  assign drain        = rsp_valid_o && rsp_ready_i;
  assign rsp_result_o = rd_entry.result;
  assign rsp_status_o = rd_entry.status;

  assign busy_o          = (count_q != '0) || fpu_busy_i;
  assign fpu_flush_o     = flush_i;
  // Slots are reserved at allocation, so results can always be taken.
  assign fpu_out_ready_o = active_q;

  assign fpu_in_valid_o = in_valid_q;
  assign fpu_operands_o = ops_q;
  assign fpu_ctrl_o     = ctrl_q;
  assign fpu_tag_o      = tag_q;

  assign wr_entry = '{result: fpu_result_i, status: fpu_status_i};

  // Occupancy: a same-cycle accept and drain cancel out.
  always_comb begin
    count_d = count_q;
    if (accept && !drain) begin
      count_d = count_q + 1'b1;
    end else if (!accept && drain) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers, occupancy and the issue register towards the FPU.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q   <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      in_valid_q <= 1'b0;
      ops_q      <= '0;
      ctrl_q     <= '0;
      tag_q      <= '0;
    end else begin
      active_q <= 1'b1;
      if (flush_i) begin
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        in_valid_q <= 1'b0;
      end else begin
        if (accept) begin
          in_valid_q <= 1'b1;
          ops_q      <= req_operands_i;
          ctrl_q     <= req_ctrl_i;
          tag_q      <= tail_q;
          tail_q     <= tail_q + 1'b1;
        end else if (fpu_in_ready_i) begin
          in_valid_q <= 1'b0;
        end
        if (drain) begin
          head_q <= head_q + 1'b1;
        end
        count_q <= count_d;
      end
    end
  end

  fpu_issue_rob_mem #(
    .IDX_W   (TAG_WIDTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .wr_en_i     (fpu_out_valid_i),
    .wr_idx_i    (fpu_tag_i),
    .wr_data_i   (wr_entry),
    .alloc_en_i  (accept),
    .alloc_idx_i (tail_q),
    .pop_en_i    (drain),
    .rd_idx_i    (head_q),
    .rd_data_o   (rd_entry),
    .rd_done_o   (head_done)
  );

`ifdef FPU_ISSUE_STATS_EN
  logic [31:0] issued_q, stall_q;

  // Saturating activity counters; only reset clears them, not flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (in_valid_q && fpu_in_ready_i) issued_q <= sat_inc(issued_q);
      if (req_valid_i && !req_ready_o)  stall_q  <= sat_inc(stall_q);
    end
  end

  assign stat_issued_o = issued_q;
  assign stat_stall_o  = stall_q;
`endif

endmodule

// File: tb/tb_fpu_issue_rob.sv
// Bench for fpu_issue_rob: directed scenarios with a scoreboard of expected
// in-order responses and a small FPU model that returns results by tag.
module tb_fpu_issue_rob;
  import fpu_issue_pkg::*;

  localparam int unsigned FLEN  = 64;
  localparam int unsigned TW    = 2;
  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              req_valid, req_ready;
  logic [3*FLEN-1:0] req_operands;
  logic [16:0]       req_ctrl;
  logic              flush;
  logic              rsp_valid, rsp_ready;
  logic [FLEN-1:0]   rsp_result;
  logic [4:0]        rsp_status;
  logic              busy;
  logic              fpu_in_valid, fpu_in_ready;
  logic [3*FLEN-1:0] fpu_operands;
  logic [16:0]       fpu_ctrl;
  logic [TW-1:0]     fpu_tag;
  logic              fpu_flush;
  logic              fpu_out_valid, fpu_out_ready;
  logic [FLEN-1:0]   fpu_result;
  logic [4:0]        fpu_status;
  logic [TW-1:0]     fpu_rtag;
  logic              fpu_busy;
`ifdef FPU_ISSUE_STATS_EN
  logic [31:0]       stat_issued, stat_stall;
`endif

  always #5 clk = ~clk;

  fpu_issue_rob #(
    .FLEN      (FLEN),
    .TAG_WIDTH (TW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_operands_i  (req_operands),
    .req_ctrl_i      (req_ctrl),
    .flush_i         (flush),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_result_o    (rsp_result),
    .rsp_status_o    (rsp_status),
    .busy_o          (busy),
    .fpu_in_valid_o  (fpu_in_valid),
    .fpu_in_ready_i  (fpu_in_ready),
    .fpu_operands_o  (fpu_operands),
    .fpu_ctrl_o      (fpu_ctrl),
    .fpu_tag_o       (fpu_tag),
    .fpu_flush_o     (fpu_flush),
    .fpu_out_valid_i (fpu_out_valid),
    .fpu_out_ready_o (fpu_out_ready),
    .fpu_result_i    (fpu_result),
    .fpu_status_i    (fpu_status),
    .fpu_tag_i       (fpu_rtag),
    .fpu_busy_i      (fpu_busy)
`ifdef FPU_ISSUE_STATS_EN
    ,
    .stat_issued_o   (stat_issued),
    .stat_stall_o    (stat_stall)
`endif
  );

  typedef struct packed {
    logic [FLEN-1:0] res;
    logic [4:0]      st;
  } exp_t;

  int                n_checks = 0;
  int                n_errors = 0;
  exp_t              exp_q[$];
  exp_t              slot_exp [DEPTH];
  logic [TW-1:0]     tb_tail;
  logic [3*FLEN-1:0] last_ops;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3*FLEN-1:0] rnd_ops();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    rst_ni        = 1'b0;
    req_valid     = 1'b0;
    req_operands  = '0;
    req_ctrl      = '0;
    flush         = 1'b0;
    rsp_ready     = 1'b0;
    fpu_in_ready  = 1'b1;
    fpu_out_valid = 1'b0;
    fpu_result    = '0;
    fpu_status    = '0;
    fpu_rtag      = '0;
    fpu_busy      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni  = 1'b1;
    tb_tail = '0;
    exp_q.delete();
    @(negedge clk);
  endtask

  // Drive one request, optionally with the FPU refusing the previous op for
  // 'stall' cycles; records the expected response for the scoreboard.
  task automatic issue(input logic [3*FLEN-1:0] ops, input logic [16:0] ctrl,
                       input logic [FLEN-1:0] res, input logic [4:0] st, input int stall);
    logic [TW-1:0] prev_tag;
    prev_tag     = tb_tail - 1'b1;
    req_valid    = 1'b1;
    req_operands = ops;
    req_ctrl     = ctrl;
    if (stall > 0) fpu_in_ready = 1'b0;
    for (int c = 0; c < stall; c++) begin
      #1;
      check_eq("stall_req_ready", req_ready, 1'b0);
      check_eq("stall_in_valid", fpu_in_valid, 1'b1);
      check_eq("stall_operands", fpu_operands, last_ops);
      check_eq("stall_tag", fpu_tag, prev_tag);
      @(negedge clk);
    end
    fpu_in_ready = 1'b1;
    #1;
    check_eq("req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("in_valid", fpu_in_valid, 1'b1);
    check_eq("in_tag", fpu_tag, tb_tail);
    check_eq("in_operands", fpu_operands, ops);
    check_eq("in_ctrl", fpu_ctrl, ctrl);
    slot_exp[tb_tail] = '{res: res, st: st};
    exp_q.push_back('{res: res, st: st});
    last_ops = ops;
    tb_tail  = tb_tail + 1'b1;
  endtask

  task automatic fpu_return(input logic [TW-1:0] tag);
    fpu_out_valid = 1'b1;
    fpu_rtag      = tag;
    fpu_result    = slot_exp[tag].res;
    fpu_status    = slot_exp[tag].st;
    @(negedge clk);
    fpu_out_valid = 1'b0;
  endtask

  task automatic drain_one(input string tag);
    exp_t e;
    int   waited = 0;
    while (!rsp_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!rsp_valid) begin
      check_eq({tag, "_timeout"}, rsp_valid, 1'b1);
    end else if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_result"}, rsp_result, e.res);
      check_eq({tag, "_status"}, rsp_status, e.st);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    exp_t e;
    // Reset values, sampled while reset is asserted.
    rst_ni = 1'b0;
    req_valid = 1'b0; req_operands = '0; req_ctrl = '0; flush = 1'b0; rsp_ready = 1'b0;
    fpu_in_ready = 1'b1; fpu_out_valid = 1'b0; fpu_result = '0; fpu_status = '0;
    fpu_rtag = '0; fpu_busy = 1'b0;
    #12;
    check_eq("rst_req_ready", req_ready, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_in_valid", fpu_in_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_out_ready", fpu_out_ready, 1'b0);
    check_eq("rst_result", rsp_result, '0);
    do_reset();
    check_eq("out_ready_after_rst", fpu_out_ready, 1'b1);

    // Single op: issue, FPU answers after a few cycles, retire.
    issue(rnd_ops(), 17'h1A5C3, 64'h3FF0000000000000, 5'h01, 0);
    check_eq("single_flush_low", fpu_flush, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_eq("single_wait_rsp", rsp_valid, 1'b0);
      check_eq("single_busy", busy, 1'b1);
    end
    fpu_return(0);
    check_eq("single_rsp_valid", rsp_valid, 1'b1);
    drain_one("single");
    check_eq("single_idle", busy, 1'b0);
    check_eq("single_rsp_gone", rsp_valid, 1'b0);
    fpu_busy = 1'b1;
    #1;
    check_eq("busy_from_fpu", busy, 1'b1);
    fpu_busy = 1'b0;

    // Fill: four tags, the fifth waits until a drain has registered.
    do_reset();
    for (int i = 0; i < 4; i++) issue(rnd_ops(), 17'(i * 777), 64'(i + 100), 5'(i), 0);
    req_valid    = 1'b1;
    req_operands = rnd_ops();
    req_ctrl     = 17'h00F0F;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("full_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    fpu_return(0);
    check_eq("full_rsp_valid", rsp_valid, 1'b1);
    e = exp_q.pop_front();
    check_eq("full_rsp_result", rsp_result, e.res);
    rsp_ready = 1'b1;
    #1;
    check_eq("full_drain_same_cycle", req_ready, 1'b0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check_eq("full_after_drain", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("full_wrap_tag", fpu_tag, tb_tail);
    check_eq("full_wrap_tag0", fpu_tag, 2'd0);
    slot_exp[tb_tail] = '{res: 64'hDEAD_0005, st: 5'h1F};
    exp_q.push_back('{res: 64'hDEAD_0005, st: 5'h1F});
    tb_tail = tb_tail + 1'b1;
    fpu_return(1); fpu_return(2); fpu_return(3); fpu_return(0);
    for (int i = 0; i < 4; i++) drain_one("fill");
    check_eq("fill_idle", busy, 1'b0);

    // Out of order: returns 2, 0, 1; responses still 0, 1, 2.
    do_reset();
    for (int i = 0; i < 3; i++) issue(rnd_ops(), 17'(i + 5), 64'hC000 + 64'(i), 5'(1 << i), 0);
    fpu_return(2);
    repeat (2) begin
      check_eq("ooo_hold", rsp_valid, 1'b0);
      @(negedge clk);
    end
    fpu_return(0);
    drain_one("ooo0");
    check_eq("ooo_wait_tag1", rsp_valid, 1'b0);
    fpu_return(1);
    drain_one("ooo1");
    drain_one("ooo2");

    // Backpressure: FPU refuses the first op for 4 cycles.
    do_reset();
    issue(rnd_ops(), 17'h12345, 64'hB0, 5'h02, 0);
    issue(rnd_ops(), 17'h0ABCD, 64'hB1, 5'h04, 4);
    @(negedge clk);
    check_eq("bp_in_valid_clear", fpu_in_valid, 1'b0);
    fpu_return(1);
    fpu_return(0);
    drain_one("bp0");
    drain_one("bp1");

    // Flush with three in flight and a result landing in the same cycle.
    do_reset();
    for (int i = 0; i < 3; i++) issue(rnd_ops(), 17'(i), 64'hF00 + 64'(i), 5'h00, 0);
    fpu_return(0);
    check_eq("flush_pre_rsp", rsp_valid, 1'b1);
    flush         = 1'b1;
    fpu_out_valid = 1'b1;
    fpu_rtag      = 2'd1;
    fpu_result    = 64'hBAD;
    #1;
    check_eq("flush_pass", fpu_flush, 1'b1);
    check_eq("flush_rsp_gated", rsp_valid, 1'b0);
    check_eq("flush_req_ready", req_ready, 1'b0);
    @(negedge clk);
    flush         = 1'b0;
    fpu_out_valid = 1'b0;
    check_eq("flush_busy", busy, 1'b0);
    check_eq("flush_rsp", rsp_valid, 1'b0);
    check_eq("flush_in_valid", fpu_in_valid, 1'b0);
    exp_q.delete();
    tb_tail = '0;
    issue(rnd_ops(), 17'h00111, 64'hA0, 5'h08, 0);
    issue(rnd_ops(), 17'h00222, 64'hA1, 5'h10, 0);
    repeat (2) begin
      @(negedge clk);
      check_eq("flush_done_cleared", rsp_valid, 1'b0);
    end
    fpu_return(0);
    drain_one("post_flush0");
    repeat (2) begin
      check_eq("flush_result_dropped", rsp_valid, 1'b0);
      @(negedge clk);
    end
    fpu_return(1);
    drain_one("post_flush1");

`ifdef FPU_ISSUE_STATS_EN
    // Six requests, two stalled three cycles each.
    do_reset();
    for (int g = 0; g < 2; g++) begin
      issue(rnd_ops(), 17'h1, 64'h50 + 64'(g), 5'h0, 0);
      issue(rnd_ops(), 17'h2, 64'h60 + 64'(g), 5'h0, 3);
      issue(rnd_ops(), 17'h3, 64'h70 + 64'(g), 5'h0, 0);
      for (int k = 3; k > 0; k--) fpu_return(tb_tail - 2'(k));
      for (int k = 0; k < 3; k++) drain_one("stats");
    end
    check_eq("stat_issued", stat_issued, 32'd6);
    check_eq("stat_stall", stat_stall, 32'd6);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_rob.md
Name: fpu_issue_rob

Overview:
- Initiator side of the FPU handshake: accepts FP requests from the core, assigns tags, and drives the FPU wrapper's input port (operands/control/tag, in_valid/in_ready, flush).
- Collects FPU results, which can return out of order (the iterative DIVSQRT unit vs. pipelined units), by tag into a reorder buffer (ROB).
- Returns results to the core strictly in issue order.
- Sits between the core FP dispatch stage and the FPU wrapper.

Parameters:
- FLEN, 64, operand/result width.
- TAG_WIDTH, 2, tag width; ROB depth DEPTH = 2**TAG_WIDTH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  core request ready
- req_operands_i  in  3*FLEN  operands {op2,op1,op0}
- req_ctrl_i  in  CTRL_W(17)  packed ctrl_t {rnd_mode 3, op 4, op_mod 1, src_fmt 3, dst_fmt 3, int_fmt 2, vectorial 1}
- flush_i  in  1  kill all in-flight work
- rsp_valid_o  out  1  in-order result valid
- rsp_ready_i  in  1  core accepts result
- rsp_result_o  out  FLEN  result
- rsp_status_o  out  5  fflags {NV,DZ,OF,UF,NX}
- busy_o  out  1  work outstanding
- fpu_in_valid_o  out  1  to FPU in_valid
- fpu_in_ready_i  in  1  from FPU in_ready
- fpu_operands_o  out  3*FLEN  to FPU
- fpu_ctrl_o  out  CTRL_W  to FPU, unpacked into its enum ports
- fpu_tag_o  out  TAG_WIDTH  to FPU tag
- fpu_flush_o  out  1  to FPU flush
- fpu_out_valid_i  in  1  FPU result valid
- fpu_out_ready_o  out  1  FPU result ready
- fpu_result_i  in  FLEN  FPU result
- fpu_status_i  in  5  FPU status
- fpu_tag_i  in  TAG_WIDTH  FPU result tag
- fpu_busy_i  in  1  FPU busy

Behaviour:
- Reset (async, rst_ni=0):
  - All outputs 0, except fpu_out_ready_o=1 after reset release.
  - head, tail and count are 0; all done bits are cleared.
  - A reset mid-operation discards everything.
- Issue register:
  - fpu_in_* are driven from a register.
  - A request is accepted when req_valid_i && req_ready_o.
  - req_ready_o = !flush_i && (count < DEPTH) && (!fpu_in_valid_o || fpu_in_ready_i).
  - On accept: register payload, set fpu_tag_o=tail, tail++ (wraps mod DEPTH), count++, done[tail]=0.
  - fpu_in_valid_o rises the cycle after accept.
  - fpu_in_valid_o holds, with payload stable, until fpu_in_ready_i. It then clears unless a new accept happens in the same cycle.
- Full boundary:
  - count==DEPTH forces req_ready_o=0.
  - A drain in the same cycle does not free a slot until the next cycle (registered count).
- Result capture:
  - fpu_out_ready_o=1 always, since slots are reserved at allocation.
  - On fpu_out_valid_i: rob[fpu_tag_i] <= {result,status}, done[fpu_tag_i]=1.
  - A result to the head slot is visible on rsp_valid_o one cycle later.
- Drain:
  - rsp_valid_o = done[head] && count!=0; rsp_result_o and rsp_status_o come from rob[head].
  - On rsp_ready_i: done[head]=0, head++, count--.
  - Simultaneous accept and drain leaves count unchanged.
- Flush:
  - fpu_flush_o = flush_i, combinational, so the FPU kills its work in the same cycle.
  - The next cycle, fpu_in_valid_o=0, head=tail=count=0 and all done bits are 0.
  - Any fpu_out_valid_i in the flush cycle is discarded.
  - rsp_valid_o is forced to 0 during flush_i.
- busy_o = (count!=0) || fpu_busy_i.

Optional Feature:
- Macro FPU_ISSUE_STATS_EN.
- When defined, adds outputs stat_issued_o[31:0], counting fpu_in handshakes, and stat_stall_o[31:0], counting cycles with req_valid_i && !req_ready_o.
- Both counters are saturating, reset to 0, and are not cleared by flush.
- When undefined, these ports and counters do not exist.

Decomposition:
- Package fpu_issue_pkg holds: ctrl_t packed struct with the field widths matching the FPU enums, CTRL_W=17, STATUS_W=5, and rob_entry_t {result, status}.
- One sub-module, fpu_issue_rob_mem: a DEPTH-entry storage array plus done bits, with one write port by tag, one read port at head, and a synchronous clear on flush.

Test Plan:
- Single op:
  - Stimulus: req accepted at cycle 0.
  - Response: fpu_in_valid_o=1 and fpu_tag_o=0 at cycle 1. FPU returns tag 0, result 0x3FF0000000000000, at cycle 5; rsp_valid_o=1 at cycle 6 with the same result; after rsp_ready_i, busy_o=0.
- Fill:
  - Stimulus: 5 back-to-back requests with TAG_WIDTH=2 and no FPU returns.
  - Response: tags 0,1,2,3 issued; req_ready_o=0 for the 5th until the first drain plus one cycle.
- Out of order:
  - Stimulus: issue tags 0,1,2; FPU returns 2, then 0, then 1.
  - Response: rsp order is 0,1,2. rsp_valid_o stays 0 while only tag 2 has returned.
- Backpressure:
  - Stimulus: fpu_in_ready_i=0 for 4 cycles.
  - Response: fpu_in_valid_o, operands and tag stay stable; req_ready_o=0 throughout.
- Flush:
  - Stimulus: flush with 3 in flight and an FPU result arriving in the same cycle.
  - Response: fpu_flush_o=1 that cycle; next cycle count=0, rsp_valid_o=0; the next request gets tag 0.
- Stats (FPU_ISSUE_STATS_EN):
  - Stimulus: 6 requests, 2 of them stalled 3 cycles each.
  - Response: stat_issued_o=6, stat_stall_o=6.
